avalon_ram_model: RTL
=====================

Name: avalon_ram_model

Overview:
Parametrised Avalon-MM slave memory model used by the CPU testbenches as unified instruction/data RAM. It supersedes the fixed preload RAM. Preload becomes a clocked port, depth and base address are parametrised, and waitrequest stalls are configurable: fixed or pseudo-random. Protocol violations by the master are detected and flagged, so each CPU test also checks bus behaviour.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
WAIT_CYCLES, 0, extra stall cycles per access (fixed mode), or maximum extra stall (random mode)
RANDOM_WAIT, 0, 0 = fixed stall; 1 = LFSR-derived stall in 0..WAIT_CYCLES
LFSR_SEED, 8'hA5, reset value of the stall LFSR; must be non-zero

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low; 0 clears all control state
address  in  32  Avalon byte address
read  in  1  read request
write  in  1  write request
writedata  in  32  write data
byteenable  in  4  byte lanes; bit0 = writedata[7:0]
waitrequest  out  1  slave stall
readdata  out  32  read data, valid in the cycle waitrequest is low with read high
load_en  in  1  preload strobe
load_addr  in  ADDR_WIDTH  preload word index
load_data  in  32  preload word
bus_error  out  1  sticky protocol/range error flag
read_count  out  32  completed reads
write_count  out  32  completed writes

Behaviour:
- Reset (reset=0, async): FSM=IDLE, readdata=0, bus_error=0, both counters=0, LFSR=LFSR_SEED. Memory array is not cleared.
- waitrequest is combinational and equals (read|write) && state!=ACK. It is 0 when no request is present.
- FSM states: IDLE, WAIT, ACK.
  - IDLE with request present: load stall counter n (fixed: WAIT_CYCLES; random: lfsr % (WAIT_CYCLES+1)). Go to ACK if n==0, otherwise to WAIT.
  - WAIT: decrement n; go to ACK when n reaches 1.
  - ACK: waitrequest low; the access commits at this posedge; go to IDLE.
- Stall length: waitrequest is high for exactly 1+n cycles per access. Back-to-back accesses always see at least one waitrequest cycle each.
- Read: readdata is registered on the transition into ACK from mem[(address-BASE_ADDR)>>2]. It holds its value until the next read.
- Write: commits in ACK. Only lanes with byteenable bit set change; byteenable=0 completes with no change.
- Counters increment by 1 in ACK for a read or a write respectively. They wrap at 2**32.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, advances every clock irrespective of bus activity.
- Preload: load_en=1 writes load_data to mem[load_addr] at the posedge, full word, independent of the FSM. If the same word is written by the bus in the same cycle, preload wins.
- Out of range (address < BASE_ADDR or word index >= depth): the access completes normally. Reads return 32'h0, writes are dropped, bus_error is set.
- Misaligned (address[1:0]!=0): bus_error is set; low bits are ignored and the access completes on the aligned word.
- read&&write together: bus_error is set; treated as a write, read_count unchanged.
- Master drops the request, or changes address/read/write, while in WAIT: bus_error is set. A dropped request returns to IDLE with no commit. A changed request continues using the new values.
- bus_error clears only on reset.
- Reset mid-access: FSM returns to IDLE immediately; no partial write occurs; a request still held after reset release restarts from IDLE.

Test Plan:
- Preload words at index 1..3 (32'h24020010, 0, 32'h1C600002), WAIT_CYCLES=0; read byte addr 0x4 -> waitrequest high 1 cycle, readdata=32'h24020010, read_count=1, bus_error=0.
- WAIT_CYCLES=3 fixed; write 32'hDEADBEEF to 0x8 with byteenable=4'b0101, then read 0x8 -> waitrequest high 4 cycles per access, readdata=32'h00AD00EF.
- RANDOM_WAIT=1, WAIT_CYCLES=3; 50 back-to-back reads -> every stall is in 1..4 cycles, at least two distinct stall lengths occur, data matches preload, read_count=50.
- Read address BASE_ADDR+4*2**ADDR_WIDTH -> readdata=0, bus_error=1. Follow with a read of 0x3 -> aligned word 0 returned, bus_error stays 1.
- WAIT_CYCLES=2; assert write, deassert it during WAIT -> no memory change, write_count=0, bus_error=1. Apply reset -> bus_error=0, counters=0.
- Bus write to index 5 with 32'h11111111 in the same cycle as a preload of 32'h22222222 to index 5 -> subsequent read returns 32'h22222222.

Source files
------------

// File: rtl/avalon_ram_model.sv
// ----------------------------------------------------------------------------
// avalon_ram_model
//
// Avalon-MM slave memory model used as unified instruction/data RAM by the
// CPU testbenches. Holds 2**ADDR_WIDTH 32-bit words mapped at BASE_ADDR.
// Every access is stalled for 1+n cycles. n is either the fixed WAIT_CYCLES
// or a pseudo-random value in 0..WAIT_CYCLES taken from a free-running LFSR.
// Master protocol violations and out-of-range accesses raise a sticky
// bus_error flag.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset of all control state
//   address      Avalon byte address
//   read/write   request strobes, held by the master until waitrequest falls
//   writedata    write data
//   byteenable   write byte lanes, bit0 selects writedata[7:0]
//   waitrequest  slave stall; low only in the ACK cycle of a request
//   readdata     read data, valid while waitrequest is low with read high
//   load_en      preload strobe; writes load_data to mem[load_addr]
//   load_addr    preload word index
//   load_data    preload word
//   bus_error    sticky protocol/range error flag, cleared only by reset
//   read_count   number of completed reads (wraps at 2**32)
//   write_count  number of completed writes (wraps at 2**32)
// ----------------------------------------------------------------------------
module avalon_ram_model #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          RANDOM_WAIT = 1'b0,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  bus_error,
    output logic [31:0]           read_count,
    output logic [31:0]           write_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] MOD_W = 32'(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      rcnt_q, rcnt_d;
    logic [31:0]      wcnt_q, wcnt_d;
    logic             bus_error_q, bus_error_d;
    logic [7:0]       lfsr_q, lfsr_d;

    // Snapshot of the request taken when it was first seen, used to detect
    // a master that changes its request while stalled.
    logic [31:0]      lat_addr_q, lat_addr_d;
    logic             lat_rd_q, lat_rd_d;
    logic             lat_wr_q, lat_wr_d;

    logic [31:0]      mem_q [DEPTH];

    logic                  req;
    logic [31:0]           offset;
    logic                  in_range;
    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [CNT_W-1:0]      stall_n;
    logic                  changed;
    logic                  enter_ack;
    logic                  mem_we;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign req        = read | write;
    assign offset     = address - BASE_ADDR;
    // Below-base addresses wrap to large offsets, so the explicit compare
    // is needed in addition to the upper-bits test.
    assign in_range   = (address >= BASE_ADDR) &&
                        ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
    assign misaligned = (address[1:0] != 2'b00);
    assign word_idx   = offset[ADDR_WIDTH+1:2];

    assign changed = (address != lat_addr_q) || (read != lat_rd_q) ||
                     (write != lat_wr_q);

    // Stall length drawn when a request is first seen in IDLE.
    always_comb begin
        if (RANDOM_WAIT) begin
            stall_n = CNT_W'({24'd0, lfsr_q} % MOD_W);
        end else begin
            stall_n = CNT_W'(WAIT_CYCLES);
        end
    end

    assign waitrequest = req && (state_q != S_ACK);

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        readdata_d  = readdata_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        bus_error_d = bus_error_q;
        lat_addr_d  = lat_addr_q;
        lat_rd_d    = lat_rd_q;
        lat_wr_d    = lat_wr_q;
        enter_ack   = 1'b0;
        mem_we      = 1'b0;
        // x^8 + x^6 + x^5 + x^4 + 1, free running
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    lat_addr_d = address;
                    lat_rd_d   = read;
                    lat_wr_d   = write;
                    if (stall_n == '0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = stall_n;
                    end
                end
            end

            S_WAIT: begin
                if (!req) begin
                    // Abandoned request: flag it and drop it without commit.
                    bus_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    if (changed) begin
                        // Keep stalling, but follow the new request.
                        bus_error_d = 1'b1;
                        lat_addr_d  = address;
                        lat_rd_d    = read;
                        lat_wr_d    = write;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            S_ACK: begin
                state_d = S_IDLE;
                if (req) begin
                    // read together with write is handled as a write.
                    if (write) begin
                        wcnt_d = wcnt_q + 32'd1;
                        mem_we = in_range;
                    end else begin
                        rcnt_d = rcnt_q + 32'd1;
                    end
                    if (!in_range || misaligned || (read && write)) begin
                        bus_error_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is captured one edge ahead so it is stable throughout
        // the ACK cycle.
        if (enter_ack && read && !write) begin
            readdata_d = in_range ? mem_q[word_idx] : 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            readdata_q  <= 32'h0;
            rcnt_q      <= 32'h0;
            wcnt_q      <= 32'h0;
            bus_error_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            bus_error_q <= bus_error_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Request snapshot only matters while in WAIT, so it needs no reset.
    always_ff @(posedge clk) begin
        lat_addr_q <= lat_addr_d;
        lat_rd_q   <= lat_rd_d;
        lat_wr_q   <= lat_wr_d;
    end

    // ------------------------------------------------------------------
    // Memory array (never cleared). The preload assignment comes last so
    // it overrides a bus write to the same word in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    mem_q[word_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign readdata    = readdata_q;
    assign bus_error   = bus_error_q;
    assign read_count  = rcnt_q;
    assign write_count = wcnt_q;

endmodule
